// File: rtl/hsi_obi_cmd_master.sv
// OBI initiator that runs one HSI vector-core job: program, start, poll STATUS, clear flags, report.
// Optional poll-limit watchdog is compiled in when HSI_CMD_TIMEOUT_EN is defined.
module hsi_obi_cmd_master #(
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int unsigned OP_CODE_WIDTH   = 4,
    parameter int unsigned NUM_BANDS_WIDTH = 32,
    parameter int unsigned ERR_WIDTH       = 4,
    parameter int unsigned POLL_GAP        = 4,
    parameter int unsigned TIMEOUT_POLLS   = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [OP_CODE_WIDTH-1:0]   job_op_code_i,
    input  logic [NUM_BANDS_WIDTH-1:0] job_num_bands_i,
    output logic                       res_valid_o,
    output logic [ERR_WIDTH-1:0]       res_error_code_o,
    output logic                       res_bus_err_o,
    output logic                       res_timeout_o,
    output logic                       req_o,
    output logic                       we_o,
    output logic [3:0]                 be_o,
    output logic [31:0]                addr_o,
    output logic [31:0]                wdata_o,
    input  logic                       gnt_i,
    input  logic                       rvalid_i,
    input  logic                       err_i,
    input  logic [31:0]                rdata_i
);
    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_OP, ST_WR_NB, ST_WR_START, ST_POLL_GAP, ST_RD_STATUS, ST_CLEAR, ST_RESULT
    } state_e;

    state_e                     state_q, state_d;
    logic                       pend_q, pend_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [OP_CODE_WIDTH-1:0]   op_q, op_d;
    logic [NUM_BANDS_WIDTH-1:0] nb_q, nb_d;
    logic [ERR_WIDTH-1:0]       err_code_q, err_code_d;
    logic                       done_q, done_d;
    logic                       bus_err_q, bus_err_d;
    logic                       tmo_q, tmo_d;
    logic                       job_ready_q, job_ready_d;
    logic                       req_q, req_d, we_q, we_d;
    logic [3:0]                 be_q, be_d;
    logic [31:0]                addr_q, addr_d, wdata_q, wdata_d;
    logic                       res_valid_q, res_valid_d;
    logic [ERR_WIDTH-1:0]       res_err_q, res_err_d;
    logic                       res_bus_err_q, res_bus_err_d;
    logic                       res_tmo_q, res_tmo_d;
    logic                       in_access_c, acc_done_c, poll_limit_c, unused_c;

    function automatic logic is_access(input state_e s);
        return s inside {ST_WR_OP, ST_WR_NB, ST_WR_START, ST_RD_STATUS, ST_CLEAR};
    endfunction

    // An access completes on rvalid once granted, including grant and response in one cycle
    assign in_access_c = is_access(state_q);
    assign acc_done_c  = in_access_c && rvalid_i && (pend_q || gnt_i);

`ifdef HSI_CMD_TIMEOUT_EN
    localparam int unsigned PCNT_W = $clog2(TIMEOUT_POLLS + 1);
    logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d, poll_next_c;

    assign poll_next_c  = poll_cnt_q + PCNT_W'(1);
    assign poll_limit_c = (poll_next_c == PCNT_W'(TIMEOUT_POLLS));
    assign unused_c     = ^rdata_i[31:ERR_WIDTH+1];

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        if (state_q == ST_IDLE) begin
            poll_cnt_d = '0;
        end else if (state_q == ST_RD_STATUS && acc_done_c) begin
            poll_cnt_d = poll_next_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) poll_cnt_q <= '0;
        else       poll_cnt_q <= poll_cnt_d;
    end
`else
    assign poll_limit_c = 1'b0;
    assign unused_c     = ^{rdata_i[31:ERR_WIDTH+1], 32'(TIMEOUT_POLLS)};
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        gap_d      = gap_q;
        op_d       = op_q;
        nb_d       = nb_q;
        err_code_d = err_code_q;
        done_d     = done_q;
        bus_err_d  = bus_err_q;
        tmo_d      = tmo_q;

        if (in_access_c && !pend_q && gnt_i && !rvalid_i) pend_d = 1'b1;
        if (acc_done_c) pend_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (job_valid_i && job_ready_q) begin
                    op_d       = job_op_code_i;
                    nb_d       = job_num_bands_i;
                    err_code_d = '0;
                    done_d     = 1'b0;
                    bus_err_d  = 1'b0;
                    tmo_d      = 1'b0;
                    state_d    = ST_WR_OP;
                end
            end
            ST_WR_OP:    if (acc_done_c) state_d = ST_WR_NB;
            ST_WR_NB:    if (acc_done_c) state_d = ST_WR_START;
            ST_WR_START: if (acc_done_c) state_d = ST_RD_STATUS;
            ST_RD_STATUS: begin
                if (acc_done_c) begin
                    done_d     = rdata_i[0];
                    err_code_d = rdata_i[ERR_WIDTH:1];
                    gap_d      = '0;
                    if (rdata_i[0] || (|rdata_i[ERR_WIDTH:1])) begin
                        state_d = ST_CLEAR;
                    end else if (poll_limit_c) begin
                        tmo_d   = 1'b1;
                        state_d = ST_CLEAR;
                    end else if (POLL_GAP == 0) begin
                        state_d = ST_RD_STATUS;
                    end else begin
                        state_d = ST_POLL_GAP;
                    end
                end
            end
            ST_POLL_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = ST_RD_STATUS;
                else                               gap_d   = gap_q + GAP_W'(1);
            end
            ST_CLEAR:  if (acc_done_c) state_d = ST_RESULT;
            ST_RESULT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A failed response aborts the job, skipping any clear
        if (acc_done_c && err_i) begin
            bus_err_d  = 1'b1;
            err_code_d = '0;
            state_d    = ST_RESULT;
        end

        job_ready_d = (state_d == ST_IDLE);
        req_d       = is_access(state_d) && !pend_d;
        we_d        = 1'b0;
        be_d        = 4'h0;
        addr_d      = 32'h0;
        wdata_d     = 32'h0;
        if (req_d) begin
            case (state_d)
                ST_WR_OP: begin
                    we_d = 1'b1; be_d = 4'h1; addr_d = BASE_ADDR + 32'h00; wdata_d = 32'(op_d);
                end
                ST_WR_NB: begin
                    we_d = 1'b1; be_d = 4'hF; addr_d = BASE_ADDR + 32'h04; wdata_d = 32'(nb_d);
                end
                ST_WR_START: begin
                    we_d = 1'b1; be_d = 4'h1; addr_d = BASE_ADDR + 32'h08; wdata_d = 32'h1;
                end
                ST_RD_STATUS: begin
                    be_d = 4'hF; addr_d = BASE_ADDR + 32'h0C;
                end
                ST_CLEAR: begin
                    we_d = 1'b1; be_d = 4'h1; addr_d = BASE_ADDR + 32'h08;
                    wdata_d = {29'b0, (err_code_d != '0), done_d, 1'b0};
                end
                default: ;
            endcase
        end

        res_valid_d   = (state_d == ST_RESULT);
        res_err_d     = res_err_q;
        res_bus_err_d = res_bus_err_q;
        res_tmo_d     = res_tmo_q;
        if (state_d == ST_RESULT) begin
            res_err_d     = err_code_d;
            res_bus_err_d = bus_err_d;
            res_tmo_d     = tmo_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            pend_q        <= 1'b0;
            gap_q         <= '0;
            op_q          <= '0;
            nb_q          <= '0;
            err_code_q    <= '0;
            done_q        <= 1'b0;
            bus_err_q     <= 1'b0;
            tmo_q         <= 1'b0;
            job_ready_q   <= 1'b1;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            be_q          <= 4'h0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            res_valid_q   <= 1'b0;
            res_err_q     <= '0;
            res_bus_err_q <= 1'b0;
            res_tmo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            gap_q         <= gap_d;
            op_q          <= op_d;
            nb_q          <= nb_d;
            err_code_q    <= err_code_d;
            done_q        <= done_d;
            bus_err_q     <= bus_err_d;
            tmo_q         <= tmo_d;
            job_ready_q   <= job_ready_d;
            req_q         <= req_d;
            we_q          <= we_d;
            be_q          <= be_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            res_valid_q   <= res_valid_d;
            res_err_q     <= res_err_d;
            res_bus_err_q <= res_bus_err_d;
            res_tmo_q     <= res_tmo_d;
        end
    end

    assign job_ready_o      = job_ready_q;
    assign req_o            = req_q;
    assign we_o             = we_q;
    assign be_o             = be_q;
    assign addr_o           = addr_q;
    assign wdata_o          = wdata_q;
    assign res_valid_o      = res_valid_q;
    assign res_error_code_o = res_err_q;
    assign res_bus_err_o    = res_bus_err_q;
    assign res_timeout_o    = res_tmo_q;
endmodule

// File: tb/tb_hsi_obi_cmd_master.sv
// Directed bench for hsi_obi_cmd_master: OBI slave model with access log, one task per scenario.
module tb_hsi_obi_cmd_master;
    localparam int unsigned GAP = 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        job_valid_i = 1'b0;
    logic        job_ready_o;
    logic [3:0]  job_op_code_i = 4'h0;
    logic [31:0] job_num_bands_i = 32'h0;
    logic        res_valid_o;
    logic [3:0]  res_error_code_o;
    logic        res_bus_err_o, res_timeout_o;
    logic        req_o, we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o, wdata_o;
    logic        gnt_i = 1'b0, rvalid_i = 1'b0, err_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;

    hsi_obi_cmd_master #(
        .BASE_ADDR(32'h0), .OP_CODE_WIDTH(4), .NUM_BANDS_WIDTH(32), .ERR_WIDTH(4),
        .POLL_GAP(GAP), .TIMEOUT_POLLS(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_op_code_i(job_op_code_i), .job_num_bands_i(job_num_bands_i),
        .res_valid_o(res_valid_o), .res_error_code_o(res_error_code_o),
        .res_bus_err_o(res_bus_err_o), .res_timeout_o(res_timeout_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .err_i(err_i), .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave configuration (written by tests)
    int          gnt_delay = 1;
    logic        fast_rsp = 1'b0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic [31:0] st_seq [8];
    int          st_len = 0;
    int          st_base = 0;
    logic [31:0] st_default = 32'h100;

    // Slave state and access log (written only by the slave process)
    logic [31:0] log_addr [256];
    logic        log_we [256];
    logic [3:0]  log_be [256];
    logic [31:0] log_wdata [256];
    int          log_req_cyc [256];
    int          log_gnt_cyc [256];
    int          log_n = 0;
    int          st_idx = 0;
    int          wait_cnt = 0;
    int          unstable = 0;
    int          req_start = 0;
    logic        rsp_pend = 1'b0;
    logic [31:0] rsp_addr = 32'h0, rsp_rdata = 32'h0;
    logic [31:0] f_addr = 32'h0, f_wdata = 32'h0;
    logic        f_we = 1'b0;
    logic [3:0]  f_be = 4'h0;
    int          res_cnt = 0, res_cyc = 0, acc_cyc = 0;

    always @(negedge clk) begin
        gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
        if (rst_i) begin
            rsp_pend = 1'b0;
            wait_cnt = 0;
        end else if (rsp_pend) begin
            rvalid_i = 1'b1;
            rsp_pend = 1'b0;
            err_i    = err_en && (rsp_addr == err_addr);
            rdata_i  = rsp_rdata;
        end else if (req_o) begin
            if (wait_cnt == 0) begin
                f_addr = addr_o; f_wdata = wdata_o; f_we = we_o; f_be = be_o;
                req_start = cyc;
            end else if (addr_o !== f_addr || wdata_o !== f_wdata || we_o !== f_we || be_o !== f_be) begin
                unstable++;
            end
            if (wait_cnt >= gnt_delay) begin
                gnt_i = 1'b1;
                if (log_n < 256) begin
                    log_addr[log_n] = addr_o; log_we[log_n] = we_o; log_be[log_n] = be_o;
                    log_wdata[log_n] = wdata_o; log_req_cyc[log_n] = req_start; log_gnt_cyc[log_n] = cyc;
                    log_n++;
                end
                rsp_addr  = addr_o;
                rsp_rdata = 32'h0;
                if (!we_o) begin
                    rsp_rdata = (st_idx - st_base < st_len) ? st_seq[st_idx - st_base] : st_default;
                    st_idx++;
                end
                wait_cnt = 0;
                if (fast_rsp) begin
                    rvalid_i = 1'b1;
                    err_i    = err_en && (addr_o == err_addr);
                    rdata_i  = rsp_rdata;
                end else begin
                    rsp_pend = 1'b1;
                end
            end else begin
                wait_cnt++;
            end
        end else if (wait_cnt != 0) begin
            unstable++;
            wait_cnt = 0;
        end
        if (!rst_i && job_valid_i && job_ready_o) acc_cyc = cyc;
        if (res_valid_o) begin
            res_cnt++;
            res_cyc = cyc;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_status(input logic [31:0] s0, input int len, input logic [31:0] dflt);
        st_seq[0]  = s0;
        st_len     = len;
        st_default = dflt;
        st_base    = st_idx;
    endtask

    task automatic start_job(input logic [3:0] op, input logic [31:0] nb);
        job_op_code_i = op; job_num_bands_i = nb; job_valid_i = 1'b1;
        tick();
        job_valid_i = 1'b0; job_op_code_i = 4'hF; job_num_bands_i = 32'hDEAD_BEEF;
    endtask

    task automatic wait_result(input string name, input int budget);
        int  snap = res_cnt;
        logic ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (res_cnt != snap) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_wait: no res_valid_o within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(2);
        checks++;
        if (job_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", job_ready_o);
        end
        checks++;
        if ({req_o, we_o, be_o} !== 6'h0 || addr_o !== 32'h0 || wdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wdata=%h want all 0",
                               req_o, we_o, be_o, addr_o, wdata_o);
        end
        checks++;
        if ({res_valid_o, res_error_code_o, res_bus_err_o, res_timeout_o} !== 7'h0) begin
            errors++; $display("FAIL reset_res: got v=%b code=%h be=%b to=%b want all 0",
                               res_valid_o, res_error_code_o, res_bus_err_o, res_timeout_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic_job();
        logic [31:0] e_addr [7]  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'h8};
        logic        e_we [7]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  e_be [7]    = '{4'h1, 4'hF, 4'h1, 4'hF, 4'hF, 4'hF, 4'h1};
        logic [31:0] e_wd [7]    = '{32'h2, 32'h40, 32'h1, 32'h0, 32'h0, 32'h0, 32'h2};
        int base = log_n;
        int rsnap = res_cnt;
        st_seq[1] = 32'h100;
        st_seq[2] = 32'h001;
        set_status(32'h100, 3, 32'h100);
        start_job(4'h2, 32'h40);
        checks++;
        if (job_ready_o !== 1'b0) begin
            errors++; $display("FAIL basic_busy_ready: got %b want 0", job_ready_o);
        end
        job_valid_i = 1'b1; job_op_code_i = 4'h9;
        tick(4);
        job_valid_i = 1'b0;
        wait_result("basic", 200);
        tick(4);
        checks++;
        if (log_n - base !== 7) begin
            errors++; $display("FAIL basic_count: got %0d accesses want 7", log_n - base);
        end
        for (int i = 0; i < 7; i++) begin
            int k = base + i;
            checks++;
            if (log_addr[k] !== e_addr[i] || log_we[k] !== e_we[i] || log_be[k] !== e_be[i] ||
                (e_we[i] && log_wdata[k] !== e_wd[i])) begin
                errors++;
                $display("FAIL basic_access%0d: got addr=%h we=%b be=%h wdata=%h want addr=%h we=%b be=%h wdata=%h",
                         i, log_addr[k], log_we[k], log_be[k], log_wdata[k], e_addr[i], e_we[i], e_be[i], e_wd[i]);
            end
        end
        checks++;
        if (res_cnt - rsnap !== 1) begin
            errors++; $display("FAIL basic_pulses: got %0d res_valid cycles want 1", res_cnt - rsnap);
        end
        checks++;
        if ({res_error_code_o, res_bus_err_o, res_timeout_o} !== 6'h0) begin
            errors++; $display("FAIL basic_res: got code=%h be=%b to=%b want 0 0 0",
                               res_error_code_o, res_bus_err_o, res_timeout_o);
        end
        checks++;
        if (log_req_cyc[base+1] - log_gnt_cyc[base] !== 2) begin
            errors++; $display("FAIL basic_next_req: got %0d cycles grant->req want 2",
                               log_req_cyc[base+1] - log_gnt_cyc[base]);
        end
        checks++;
        if (log_req_cyc[base+4] - log_gnt_cyc[base+3] !== int'(GAP) + 2) begin
            errors++; $display("FAIL basic_poll_gap: got %0d cycles grant->req want %0d",
                               log_req_cyc[base+4] - log_gnt_cyc[base+3], GAP + 2);
        end
    endtask

    task automatic test_latency();
        set_status(32'h001, 1, 32'h001);
        start_job(4'h1, 32'h3);
        wait_result("latency", 100);
        checks++;
        if (res_cyc - acc_cyc !== 16) begin
            errors++; $display("FAIL latency: got %0d cycles accept->result want 16", res_cyc - acc_cyc);
        end
        tick(3);
    endtask

    task automatic test_error_code();
        logic [31:0] st [3]    = '{32'h00A, 32'h003, 32'h01F};
        logic [31:0] e_clr [3] = '{32'h4, 32'h6, 32'h6};
        logic [3:0]  e_code [3] = '{4'h5, 4'h1, 4'hF};
        for (int t = 0; t < 3; t++) begin
            int base = log_n;
            set_status(st[t], 1, st[t]);
            start_job(4'h3, 32'h10);
            wait_result("errcode", 100);
            tick(3);
            checks++;
            if (log_n - base !== 5 || log_addr[base+4] !== 32'h8 || log_wdata[base+4] !== e_clr[t]) begin
                errors++; $display("FAIL errcode_clear%0d: got n=%0d addr=%h wdata=%h want n=5 addr=8 wdata=%h",
                                   t, log_n - base, log_addr[base+4], log_wdata[base+4], e_clr[t]);
            end
            checks++;
            if (res_error_code_o !== e_code[t] || res_bus_err_o !== 1'b0) begin
                errors++; $display("FAIL errcode_res%0d: got code=%h be=%b want code=%h be=0",
                                   t, res_error_code_o, res_bus_err_o, e_code[t]);
            end
        end
    endtask

    task automatic test_bus_error();
        int base = log_n;
        set_status(32'h001, 1, 32'h001);
        err_en = 1'b1; err_addr = 32'h4;
        start_job(4'h4, 32'h20);
        wait_result("buserr", 100);
        tick(8);
        err_en = 1'b0;
        checks++;
        if (log_n - base !== 2) begin
            errors++; $display("FAIL buserr_count: got %0d accesses want 2", log_n - base);
        end
        checks++;
        if (res_cyc - log_gnt_cyc[base+1] !== 2) begin
            errors++; $display("FAIL buserr_delay: got %0d cycles grant->result want 2",
                               res_cyc - log_gnt_cyc[base+1]);
        end
        checks++;
        if (res_bus_err_o !== 1'b1 || res_error_code_o !== 4'h0 || req_o !== 1'b0) begin
            errors++; $display("FAIL buserr_res: got be=%b code=%h req=%b want be=1 code=0 req=0",
                               res_bus_err_o, res_error_code_o, req_o);
        end
    endtask

    task automatic test_gnt_stall();
        int base = log_n;
        int usnap = unstable;
        set_status(32'h001, 1, 32'h001);
        gnt_delay = 7;
        start_job(4'h6, 32'h77);
        wait_result("stall", 300);
        tick(3);
        gnt_delay = 1;
        checks++;
        if (unstable !== usnap) begin
            errors++; $display("FAIL stall_stable: got %0d unstable request cycles want 0", unstable - usnap);
        end
        checks++;
        if (log_gnt_cyc[base] - log_req_cyc[base] !== 7 || log_wdata[base+1] !== 32'h77) begin
            errors++; $display("FAIL stall_wait: got %0d cycles, wdata=%h want 7 cycles, wdata=77",
                               log_gnt_cyc[base] - log_req_cyc[base], log_wdata[base+1]);
        end
        checks++;
        if (log_n - base !== 5 || res_bus_err_o !== 1'b0 || res_error_code_o !== 4'h0) begin
            errors++; $display("FAIL stall_res: got n=%0d be=%b code=%h want n=5 be=0 code=0",
                               log_n - base, res_bus_err_o, res_error_code_o);
        end
    endtask

    task automatic test_same_cycle_rsp();
        int base = log_n;
        set_status(32'h001, 1, 32'h001);
        fast_rsp = 1'b1;
        start_job(4'h7, 32'h5);
        wait_result("samecyc", 100);
        tick(3);
        fast_rsp = 1'b0;
        checks++;
        if (res_cyc - acc_cyc !== 11 || log_n - base !== 5) begin
            errors++; $display("FAIL samecyc_latency: got %0d cycles, n=%0d want 11 cycles, n=5",
                               res_cyc - acc_cyc, log_n - base);
        end
    endtask

`ifdef HSI_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int base = log_n;
        int reads = 0;
        set_status(32'h100, 0, 32'h100);
        start_job(4'h8, 32'h1);
        wait_result("timeout", 400);
        tick(3);
        for (int i = base; i < log_n; i++) if (log_addr[i] == 32'hC) reads++;
        checks++;
        if (reads !== 8 || log_n - base !== 12) begin
            errors++; $display("FAIL timeout_reads: got %0d reads, n=%0d want 8 reads, n=12", reads, log_n - base);
        end
        checks++;
        if (log_addr[log_n-1] !== 32'h8 || log_wdata[log_n-1] !== 32'h0) begin
            errors++; $display("FAIL timeout_clear: got addr=%h wdata=%h want addr=8 wdata=0",
                               log_addr[log_n-1], log_wdata[log_n-1]);
        end
        checks++;
        if (res_timeout_o !== 1'b1 || res_error_code_o !== 4'h0 || res_bus_err_o !== 1'b0) begin
            errors++; $display("FAIL timeout_res: got to=%b code=%h be=%b want to=1 code=0 be=0",
                               res_timeout_o, res_error_code_o, res_bus_err_o);
        end
    endtask
`else
    task automatic test_no_timeout();
        int base = log_n;
        int rsnap = res_cnt;
        set_status(32'h100, 0, 32'h100);
        start_job(4'h8, 32'h1);
        tick(200);
        checks++;
        if (res_cnt !== rsnap || log_n - base < 15 || res_timeout_o !== 1'b0) begin
            errors++; $display("FAIL no_timeout: got results=%0d accesses=%0d to=%b want 0 results, >=15 accesses, to=0",
                               res_cnt - rsnap, log_n - base, res_timeout_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        int base;
        logic seen = 1'b0;
        set_status(32'h100, 0, 32'h100);
        start_job(4'hA, 32'h9);
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (req_o === 1'b1 && addr_o === 32'hC) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rstmid_reach: got no STATUS request within 100 cycles want one");
        end
        rst_i = 1'b1;
        tick();
        checks++;
        if (req_o !== 1'b0 || job_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got req=%b ready=%b rv=%b want req=0 ready=1 rv=0",
                               req_o, job_ready_o, res_valid_o);
        end
        rst_i = 1'b0;
        tick(2);
        base = log_n;
        set_status(32'h001, 1, 32'h001);
        start_job(4'h5, 32'h7);
        wait_result("rstmid", 100);
        tick(3);
        checks++;
        if (log_n - base !== 5 || log_wdata[base] !== 32'h5 || log_wdata[base+1] !== 32'h7 ||
            log_wdata[base+4] !== 32'h2) begin
            errors++; $display("FAIL rstmid_fresh: got n=%0d op=%h nb=%h clr=%h want n=5 op=5 nb=7 clr=2",
                               log_n - base, log_wdata[base], log_wdata[base+1], log_wdata[base+4]);
        end
        checks++;
        if ({res_error_code_o, res_bus_err_o, res_timeout_o} !== 6'h0) begin
            errors++; $display("FAIL rstmid_res: got code=%h be=%b to=%b want 0 0 0",
                               res_error_code_o, res_bus_err_o, res_timeout_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_latency();
        test_error_code();
        test_bus_error();
        test_gnt_stall();
        test_same_cycle_rsp();
`ifdef HSI_CMD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
